// File: rtl/l2_port_arbiter_if.sv
// Bundle of the cache-side request/ack signals and the L2 port signals
// that l2_port_arbiter shares between the I-cache and the D-cache.
// The slave modport is the arbiter's view; master is the environment's view.
interface l2_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_ack;
  logic              dc_req;
  logic [ADDR_W-1:0] dc_addr;
  logic              dc_we;
  logic              dc_ack;
  logic              l2_req;
  logic [ADDR_W-1:0] l2_addr;
  logic              l2_we;
  logic              l2_done;
  logic              busy;
  logic              err;
  logic [15:0]       ic_grants;
  logic [15:0]       dc_grants;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_addr, dc_we, l2_done,
    output ic_ack, dc_ack, l2_req, l2_addr, l2_we, busy, err,
           ic_grants, dc_grants
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_addr, dc_we, l2_done,
    input  ic_ack, dc_ack, l2_req, l2_addr, l2_we, busy, err,
           ic_grants, dc_grants
  );
endinterface

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: round-robin owner selection between I-cache fills and
// D-cache fills/writebacks for the single L2 request port. One transaction
// runs at a time (IDLE -> BUSY -> DONE); a watchdog releases the owner and
// raises a sticky err if L2 never completes.
// Optional macro ARB_STATS_EN: adds saturating per-requester grant counters;
// without it ic_grants/dc_grants are tied to 0.
module l2_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  l2_port_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              owner_q;     // also serves as last_owner for round robin
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [15:0]       wd_cnt_q;
  logic              err_q;

  logic              grant;
  logic              pick_dc;
  logic              wd_expire;

  // Next-state selection: arbitration in IDLE, completion/watchdog in BUSY
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    pick_dc   = 1'b0;
    wd_expire = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ic_req || bus.dc_req) begin
          grant   = 1'b1;
          // On a tie the requester that did not own the port last time wins
          pick_dc = bus.dc_req && (!bus.ic_req || (owner_q == OWN_IC));
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.l2_done) begin
          state_d = DONE;
        end else if (wd_cnt_q == WD_LAST) begin
          wd_expire = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, owner, latched transaction fields, watchdog and sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_DC;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q  <= pick_dc;
        addr_q   <= pick_dc ? bus.dc_addr : bus.ic_addr;
        we_q     <= pick_dc & bus.dc_we;
        wd_cnt_q <= '0;
      end else if (state_q == BUSY) begin
        wd_cnt_q <= wd_cnt_q + 16'd1;
      end
      if (wd_expire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.l2_req  = (state_q == BUSY);
  assign bus.l2_addr = addr_q;
  assign bus.l2_we   = we_q;
  assign bus.busy    = (state_q == BUSY) || (state_q == DONE);
  assign bus.err     = err_q;
  assign bus.ic_ack  = (state_q == DONE) && (owner_q == OWN_IC);
  assign bus.dc_ack  = (state_q == DONE) && (owner_q == OWN_DC);

`ifdef ARB_STATS_EN
  logic [15:0] ic_grants_q;
  logic [15:0] dc_grants_q;

  // Saturating grant counters, bumped on each IDLE->BUSY transition
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ic_grants_q <= '0;
      dc_grants_q <= '0;
    end else if (grant) begin
      if (!pick_dc && (ic_grants_q != 16'hFFFF)) begin
        ic_grants_q <= ic_grants_q + 16'd1;
      end
      if (pick_dc && (dc_grants_q != 16'hFFFF)) begin
        dc_grants_q <= dc_grants_q + 16'd1;
      end
    end
  end

  assign bus.ic_grants = ic_grants_q;
  assign bus.dc_grants = dc_grants_q;
`else
  assign bus.ic_grants = '0;
  assign bus.dc_grants = '0;
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Testbench for l2_port_arbiter: directed scenarios with literal
// expectations, then randomized protocol-following requesters. A
// transaction-level model predicts every output on every cycle.
module tb_l2_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  l2_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  l2_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  // A transaction is "open" while the port is held for its owner; the
  // cycle after it closes is the owner's acknowledge cycle.
  bit              m_open   = 1'b0;
  bit              m_acking = 1'b0;
  bit              m_last_dc = 1'b1;
  int              m_held   = 0;
  bit              m_err    = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  bit              m_we     = 1'b0;
  int              m_icg    = 0;
  int              m_dcg    = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_open    <= 1'b0;
      m_acking  <= 1'b0;
      m_last_dc <= 1'b1;
      m_held    <= 0;
      m_err     <= 1'b0;
      m_addr    <= '0;
      m_we      <= 1'b0;
      m_icg     <= 0;
      m_dcg     <= 0;
    end else if (m_acking) begin
      m_acking <= 1'b0;
    end else if (m_open) begin
      m_held <= m_held + 1;
      if (bus.l2_done) begin
        m_open   <= 1'b0;
        m_acking <= 1'b1;
      end else if (m_held + 1 >= TIMEOUT) begin
        m_open   <= 1'b0;
        m_acking <= 1'b1;
        m_err    <= 1'b1;
      end
    end else if (bus.ic_req || bus.dc_req) begin
      bit win_dc;
      win_dc = bus.ic_req && bus.dc_req ? !m_last_dc : bus.dc_req;
      m_last_dc <= win_dc;
      m_open    <= 1'b1;
      m_held    <= 0;
      m_addr    <= win_dc ? bus.dc_addr : bus.ic_addr;
      m_we      <= win_dc && bus.dc_we;
      if (win_dc) m_dcg <= (m_dcg < 65535) ? m_dcg + 1 : m_dcg;
      else        m_icg <= (m_icg < 65535) ? m_icg + 1 : m_icg;
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_l2_req",  bus.l2_req,  m_open);
      chk("cyc_ic_ack",  bus.ic_ack,  m_acking && !m_last_dc);
      chk("cyc_dc_ack",  bus.dc_ack,  m_acking && m_last_dc);
      chk("cyc_busy",    bus.busy,    m_open || m_acking);
      chk("cyc_err",     bus.err,     m_err);
      chk("cyc_l2_addr", bus.l2_addr, m_addr);
      chk("cyc_l2_we",   bus.l2_we,   m_we);
`ifdef ARB_STATS_EN
      chk("cyc_ic_grants", bus.ic_grants, 16'(m_icg));
      chk("cyc_dc_grants", bus.dc_grants, 16'(m_dcg));
`else
      chk("cyc_ic_grants", bus.ic_grants, 16'd0);
      chk("cyc_dc_grants", bus.dc_grants, 16'd0);
`endif
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    bus.ic_req = 1'b0;
    bus.dc_req = 1'b0;
    bus.dc_we = 1'b0;
    bus.l2_done = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [ADDR_W-1:0] ic_a;
    logic [ADDR_W-1:0] dc_a;
    bit exp_dc [4];
    int n_busy;

    bus.ic_req  = 1'b1;
    bus.dc_req  = 1'b1;
    bus.ic_addr = 32'h0000_3000;
    bus.dc_addr = 32'h0000_4000;
    bus.dc_we   = 1'b0;
    bus.l2_done = 1'b0;

    // Test 1: reset held with both requests high, then IC wins first
    step();
    chk_en = 1'b1;
    chk("t1_rst_l2_req", bus.l2_req, 1'b0);
    chk("t1_rst_acks", {bus.ic_ack, bus.dc_ack}, 2'b00);
    step();
    chk("t1_rst_busy_err", {bus.busy, bus.err}, 2'b00);
    chk("t1_rst_l2_addr", bus.l2_addr, 32'h0);
    rst_n = 1'b1;
    step();
    chk("t1_first_grant_req", bus.l2_req, 1'b1);
    chk("t1_first_grant_ic", bus.l2_addr, 32'h0000_3000);
    bus.l2_done = 1'b1;
    step();
    chk("t1_ic_ack", {bus.ic_ack, bus.dc_ack}, 2'b10);
    bus.ic_req = 1'b0;
    bus.dc_req = 1'b0;
    bus.l2_done = 1'b0;
    step();

    // Test 2: single IC fill, L2 completes in the 3rd BUSY cycle
    do_reset();
    bus.ic_req  = 1'b1;
    bus.ic_addr = 32'h0000_1240;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_l2_req", bus.l2_req, 1'b1);
      chk("t2_l2_addr", bus.l2_addr, 32'h0000_1240);
      chk("t2_l2_we", bus.l2_we, 1'b0);
      chk("t2_no_ack", {bus.ic_ack, bus.dc_ack}, 2'b00);
    end
    bus.l2_done = 1'b1;
    step();
    chk("t2_done_l2_req", bus.l2_req, 1'b0);
    chk("t2_ic_ack", {bus.ic_ack, bus.dc_ack}, 2'b10);
    bus.ic_req  = 1'b0;
    bus.l2_done = 1'b0;
    step();
    chk("t2_ack_one_cycle", {bus.ic_ack, bus.dc_ack}, 2'b00);

    // Test 3: both requesting continuously, grants alternate IC,DC,IC,DC
    do_reset();
    ic_a = 32'h0000_5540;
    bus.ic_addr = ic_a;
    bus.dc_addr = 32'h00AB_C000;
    bus.dc_we   = 1'b1;
    bus.ic_req  = 1'b1;
    bus.dc_req  = 1'b1;
    bus.l2_done = 1'b1;
    exp_dc = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_l2_req", bus.l2_req, 1'b1);
      chk("t3_l2_addr", bus.l2_addr, exp_dc[i] ? 32'h00AB_C000 : 32'h0000_5540);
      chk("t3_l2_we", bus.l2_we, exp_dc[i]);
      step();
      chk("t3_ack", {bus.ic_ack, bus.dc_ack}, exp_dc[i] ? 2'b01 : 2'b10);
      if (i == 3) begin
        bus.ic_req = 1'b0;
        bus.dc_req = 1'b0;
      end
      step();
    end
    bus.l2_done = 1'b0;
    step();
`ifdef ARB_STATS_EN
    chk("t3_grants", {bus.ic_grants, bus.dc_grants}, {16'd2, 16'd2});
`else
    chk("t3_grants", {bus.ic_grants, bus.dc_grants}, 32'd0);
`endif

    // Test 4: DC transaction never completes -> watchdog after 4 BUSY cycles
    do_reset();
    bus.dc_addr = 32'h0000_8800;
    bus.dc_we   = 1'b0;
    bus.dc_req  = 1'b1;
    step();
    n_busy = 0;
    while (bus.l2_req && n_busy < 20) begin
      n_busy++;
      step();
    end
    chk("t4_busy_cycles", n_busy, 4);
    chk("t4_err_set", bus.err, 1'b1);
    chk("t4_dc_ack", {bus.ic_ack, bus.dc_ack}, 2'b01);
    bus.dc_req = 1'b0;
    step();
    chk("t4_dc_ack_once", bus.dc_ack, 1'b0);
    chk("t4_err_sticky", bus.err, 1'b1);
    bus.ic_addr = 32'h0000_0A00;
    bus.ic_req  = 1'b1;
    step();
    chk("t4_ic_after_l2_req", bus.l2_req, 1'b1);
    bus.l2_done = 1'b1;
    step();
    chk("t4_ic_after_ack", {bus.ic_ack, bus.dc_ack}, 2'b10);
    chk("t4_err_still", bus.err, 1'b1);
    bus.ic_req  = 1'b0;
    bus.l2_done = 1'b0;
    step();

    // Test 5: l2_done in the 4th BUSY cycle beats the watchdog
    do_reset();
    bus.dc_req = 1'b1;
    step();
    step();
    step();
    step();
    chk("t5_4th_busy", bus.l2_req, 1'b1);
    bus.l2_done = 1'b1;
    step();
    chk("t5_err_clear", bus.err, 1'b0);
    chk("t5_dc_ack", {bus.ic_ack, bus.dc_ack}, 2'b01);
    bus.dc_req  = 1'b0;
    bus.l2_done = 1'b0;
    step();

    // Test 6: reset during the 2nd BUSY cycle abandons the transaction
    do_reset();
    bus.ic_req = 1'b1;
    step();
    step();
    chk("t6_busy2", bus.l2_req, 1'b1);
    rst_n = 1'b0;
    step();
    chk("t6_l2_req_low", bus.l2_req, 1'b0);
    chk("t6_no_ack", {bus.ic_ack, bus.dc_ack, bus.err, bus.busy}, 4'b0000);
    rst_n = 1'b1;
    bus.ic_req = 1'b0;
    step();
    chk("t6_still_no_ack", {bus.ic_ack, bus.dc_ack}, 2'b00);

    // Randomized phase: protocol-following requesters, random L2 completion
    do_reset();
    dc_a = '0;
    for (int c = 0; c < 4000; c++) begin
      step();
      rst_n = ($urandom_range(0, 99) != 0);
      if (bus.ic_ack) begin
        bus.ic_req = 1'b0;
      end else if (!bus.ic_req && $urandom_range(0, 3) == 0) begin
        ic_a = $urandom;
        bus.ic_addr = ic_a;
        bus.ic_req = 1'b1;
      end
      if (bus.dc_ack) begin
        bus.dc_req = 1'b0;
      end else if (!bus.dc_req && $urandom_range(0, 3) == 0) begin
        dc_a = $urandom;
        bus.dc_addr = dc_a;
        bus.dc_we = 1'($urandom_range(0, 1));
        bus.dc_req = 1'b1;
      end
      bus.l2_done = ($urandom_range(0, 3) == 0);
    end

    step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
